// File: rtl/fifo_rx_ctrl_if.sv
// Downstream packet handshake between the RX frame controller and its consumer.
// The master drives pkt_data/pkt_valid and the slave answers with pkt_ready.
interface fifo_rx_ctrl_if;
    logic [95:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready;

    modport master (
        output pkt_data,
        output pkt_valid,
        input  pkt_ready
    );

    modport slave (
        input  pkt_data,
        input  pkt_valid,
        output pkt_ready
    );
endinterface

// File: rtl/fifo_rx_ctrl.sv
// Sequences the 12-byte FIFO frame reader, validates each frame (header + XOR)
// and forwards good frames over a valid/ready handshake with saturating stats.
module fifo_rx_ctrl #(
    parameter logic [7:0] HEADER  = 8'hAA,
    parameter int         TIMEOUT = 1024,
    parameter int         CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [11:0]   fifo_cnt,
    input  logic [11:0]   frame_len,
    output logic [11:0]   rd_num,
    output logic          rd_fs,
    input  logic          rd_fd,
    input  logic [95:0]   rd_res,
    output logic          rd_err,
    fifo_rx_ctrl_if.master pkt,
    output logic [CW-1:0] good_cnt,
    output logic [CW-1:0] bad_cnt,
    output logic [CW-1:0] tout_cnt,
    output logic          busy,
    output logic [2:0]    so
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        CHECK   = 3'd2,
        OUT     = 3'd3,
        DROP    = 3'd4,
        RELEASE = 3'd5,
        TOUT    = 3'd6
    } state_t;

    localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] tcnt;
    logic [95:0] frame;
    logic [95:0] frame_pkt;
    logic [7:0]  csum;
    logic        ok;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // frame holds reader order (byte 0 in the low byte); pkt order is reversed
    always_comb begin
        csum      = '0;
        frame_pkt = '0;
        for (int k = 1; k < 11; k++)
            csum = csum ^ frame[8*k +: 8];
        for (int k = 0; k < 12; k++)
            frame_pkt[95-8*k -: 8] = frame[8*k +: 8];
        ok = (frame[7:0] == HEADER) && (frame[95:88] == csum);
    end

    assign rd_num = frame_len;
    assign busy   = (state != IDLE);
    assign so     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tcnt          <= '0;
            frame         <= '0;
            rd_fs         <= 1'b0;
            rd_err        <= 1'b0;
            pkt.pkt_valid <= 1'b0;
            pkt.pkt_data  <= '0;
            good_cnt      <= '0;
            bad_cnt       <= '0;
            tout_cnt      <= '0;
        end else begin
            rd_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fifo_cnt >= frame_len && !rd_fd) begin
                        state <= START;
                        rd_fs <= 1'b1;
                    end
                end
                START: begin
                    // a done arriving on the limit cycle still wins
                    if (rd_fd) begin
                        frame <= rd_res;
                        tcnt  <= '0;
                        rd_fs <= 1'b0;
                        state <= CHECK;
                    end else if (tcnt == TLIM) begin
                        tcnt   <= tcnt + 16'd1;
                        rd_fs  <= 1'b0;
                        rd_err <= 1'b1;
                        state  <= TOUT;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                CHECK: begin
                    if (ok) begin
                        pkt.pkt_data  <= frame_pkt;
                        pkt.pkt_valid <= 1'b1;
                        state         <= OUT;
                    end else begin
                        state <= DROP;
                    end
                end
                OUT: begin
                    if (pkt.pkt_ready) begin
                        good_cnt      <= sat_inc(good_cnt);
                        pkt.pkt_valid <= 1'b0;
                        state         <= RELEASE;
                    end
                end
                DROP: begin
                    bad_cnt <= sat_inc(bad_cnt);
                    state   <= RELEASE;
                end
                TOUT: begin
                    tout_cnt <= sat_inc(tout_cnt);
                    tcnt     <= '0;
                    state    <= RELEASE;
                end
                RELEASE: begin
                    if (!rd_fd)
                        state <= IDLE;
                end
                default: begin
                    rd_fs         <= 1'b0;
                    pkt.pkt_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rx_ctrl.sv
// Directed bench for fifo_rx_ctrl: a default instance plus a short-timeout,
// narrow-counter instance; sel picks which one the tasks drive and observe.
module tb_fifo_rx_ctrl;

    localparam logic [95:0] GOOD1 = 96'hAA_01_02_03_04_05_06_07_08_09_0A_0B;
    localparam logic [95:0] GOOD2 = 96'hAA_10_20_30_40_50_60_70_80_90_A0_B0;
    localparam logic [95:0] BADH  = 96'h55_01_02_03_04_05_06_07_08_09_0A_0B;
    localparam logic [95:0] BADC  = 96'hAA_01_02_03_04_05_06_07_08_09_0A_0C;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [11:0] cnt;
    logic [11:0] frame_len;
    logic        rd_fd;
    logic [95:0] rd_res;
    logic        pkt_ready;
    int          n_chk;
    int          n_fail;

    logic [11:0] m_cnt, m_num, t_cnt, t_num;
    logic        m_fs, m_err, m_busy, t_fs, t_err, t_busy;
    logic [2:0]  m_so, t_so;
    logic [15:0] m_good, m_bad, m_tout;
    logic [3:0]  t_good, t_bad, t_tout;

    fifo_rx_ctrl_if m_if ();
    fifo_rx_ctrl_if t_if ();

    assign m_cnt = sel ? 12'd0 : cnt;
    assign t_cnt = sel ? cnt : 12'd0;
    assign m_if.pkt_ready = pkt_ready;
    assign t_if.pkt_ready = pkt_ready;

    fifo_rx_ctrl m (
        .clk(clk), .rst(rst), .fifo_cnt(m_cnt), .frame_len(frame_len),
        .rd_num(m_num), .rd_fs(m_fs), .rd_fd(rd_fd), .rd_res(rd_res),
        .rd_err(m_err), .pkt(m_if), .good_cnt(m_good), .bad_cnt(m_bad),
        .tout_cnt(m_tout), .busy(m_busy), .so(m_so)
    );

    fifo_rx_ctrl #(.TIMEOUT(16), .CW(4)) t (
        .clk(clk), .rst(rst), .fifo_cnt(t_cnt), .frame_len(frame_len),
        .rd_num(t_num), .rd_fs(t_fs), .rd_fd(rd_fd), .rd_res(rd_res),
        .rd_err(t_err), .pkt(t_if), .good_cnt(t_good), .bad_cnt(t_bad),
        .tout_cnt(t_tout), .busy(t_busy), .so(t_so)
    );

    wire [11:0] num  = sel ? t_num  : m_num;
    wire        fs   = sel ? t_fs   : m_fs;
    wire        err  = sel ? t_err  : m_err;
    wire        busy = sel ? t_busy : m_busy;
    wire [2:0]  so   = sel ? t_so   : m_so;
    wire        pv   = sel ? t_if.pkt_valid : m_if.pkt_valid;
    wire [95:0] pd   = sel ? t_if.pkt_data  : m_if.pkt_data;
    wire [15:0] good = sel ? {12'd0, t_good} : m_good;
    wire [15:0] bad  = sel ? {12'd0, t_bad}  : m_bad;
    wire [15:0] tout = sel ? {12'd0, t_tout} : m_tout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reader delivers byte 0 in the low byte of rd_res
    function automatic logic [95:0] to_res(input logic [95:0] p);
        logic [95:0] r;
        for (int k = 0; k < 12; k++)
            r[8*k +: 8] = p[95-8*k -: 8];
        return r;
    endfunction

    // starts a frame, feeds pkt after dly cycles, returns two edges after done
    task automatic drive_frame(input logic [95:0] p, input int dly);
        int n;
        n   = 0;
        cnt = 12'd12;
        do begin
            tick();
            n++;
        end while (fs !== 1'b1 && n < 8);
        cnt = 12'd0;
        n_chk++;
        if (fs !== 1'b1) begin
            n_fail++;
            $display("FAIL start: rd_fs=%b required 1", fs);
        end
        repeat (dly) tick();
        rd_res = to_res(p);
        rd_fd  = 1'b1;
        tick();
        tick();
    endtask

    task automatic finish_frame();
        int n;
        n     = 0;
        rd_fd = 1'b0;
        do begin
            tick();
            n++;
        end while (so !== 3'd0 && n < 8);
        n_chk++;
        if (so !== 3'd0) begin
            n_fail++;
            $display("FAIL return_idle: so=%0d required 0", so);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_chk++;
        if ({so, fs, err, pv, busy} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: so=%0d fs=%b err=%b pv=%b busy=%b required all 0",
                     so, fs, err, pv, busy);
        end
        n_chk++;
        if (pd !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_data: pkt_data=%h required 0", pd);
        end
        n_chk++;
        if ({good, bad, tout} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: good=%0d bad=%0d tout=%0d required 0", good, bad, tout);
        end
        frame_len = 12'd20;
        #1;
        n_chk++;
        if (num !== 12'd20) begin
            n_fail++;
            $display("FAIL rd_num: got %0d required 20", num);
        end
        frame_len = 12'd12;
    endtask

    task automatic test_good();
        int n;
        sel       = 1'b0;
        pkt_ready = 1'b1;
        cnt       = 12'd11;
        tick();
        tick();
        n_chk++;
        if (fs !== 1'b0 || so !== 3'd0) begin
            n_fail++;
            $display("FAIL below_len: fs=%b so=%0d required 0 0", fs, so);
        end
        cnt = 12'd12;
        tick();
        cnt = 12'd0;
        n   = 0;
        for (int i = 0; i < 20; i++) begin
            if (fs === 1'b1 && so === 3'd1) n++;
            tick();
        end
        n_chk++;
        if (n !== 20) begin
            n_fail++;
            $display("FAIL good_fs_len: fs high %0d cycles required 20", n);
        end
        rd_res = to_res(GOOD1);
        rd_fd  = 1'b1;
        tick();
        n_chk++;
        if (so !== 3'd2 || fs !== 1'b0 || pv !== 1'b0) begin
            n_fail++;
            $display("FAIL good_check: so=%0d fs=%b pv=%b required 2 0 0", so, fs, pv);
        end
        tick();
        n_chk++;
        if (pv !== 1'b1 || pd !== GOOD1) begin
            n_fail++;
            $display("FAIL good_out: pv=%b data=%h required 1 %h", pv, pd, GOOD1);
        end
        tick();
        tick();
        n_chk++;
        if (good !== 16'd1 || pv !== 1'b0 || so !== 3'd5) begin
            n_fail++;
            $display("FAIL good_accept: good=%0d pv=%b so=%0d required 1 0 5", good, pv, so);
        end
        finish_frame();
    endtask

    task automatic test_bad();
        sel       = 1'b0;
        pkt_ready = 1'b1;
        drive_frame(BADH, 3);
        n_chk++;
        if (so !== 3'd4 || pv !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_hdr_drop: so=%0d pv=%b required 4 0", so, pv);
        end
        finish_frame();
        n_chk++;
        if (bad !== 16'd1 || good !== 16'd1) begin
            n_fail++;
            $display("FAIL bad_hdr_cnt: bad=%0d good=%0d required 1 1", bad, good);
        end
        drive_frame(BADC, 2);
        finish_frame();
        n_chk++;
        if (bad !== 16'd2 || good !== 16'd1) begin
            n_fail++;
            $display("FAIL bad_sum_cnt: bad=%0d good=%0d required 2 1", bad, good);
        end
    endtask

    task automatic test_back_pressure();
        int n;
        sel       = 1'b0;
        pkt_ready = 1'b0;
        drive_frame(GOOD2, 5);
        cnt   = 12'd12;
        rd_fd = 1'b0;
        n     = 0;
        for (int i = 0; i < 50; i++) begin
            if (pv === 1'b1 && pd === GOOD2 && fs === 1'b0 && so === 3'd3) n++;
            tick();
        end
        n_chk++;
        if (n !== 50) begin
            n_fail++;
            $display("FAIL bp_hold: held %0d cycles required 50", n);
        end
        cnt       = 12'd0;
        pkt_ready = 1'b1;
        tick();
        n_chk++;
        if (good !== 16'd2 || pv !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: good=%0d pv=%b required 2 0", good, pv);
        end
        finish_frame();
    endtask

    task automatic test_boundary();
        sel   = 1'b0;
        cnt   = 12'd12;
        rd_fd = 1'b1;
        tick();
        tick();
        n_chk++;
        if (fs !== 1'b0 || so !== 3'd0) begin
            n_fail++;
            $display("FAIL fd_blocks: fs=%b so=%0d required 0 0", fs, so);
        end
        rd_fd     = 1'b0;
        cnt       = 12'd0;
        frame_len = 12'd0;
        tick();
        n_chk++;
        if (fs !== 1'b1 || so !== 3'd1) begin
            n_fail++;
            $display("FAIL len_zero: fs=%b so=%0d required 1 1", fs, so);
        end
        frame_len = 12'd12;
        rd_res    = to_res(BADC);
        rd_fd     = 1'b1;
        tick();
        tick();
        finish_frame();
        n_chk++;
        if (bad !== 16'd3) begin
            n_fail++;
            $display("FAIL len_zero_cnt: bad=%0d required 3", bad);
        end
    endtask

    task automatic test_timeout();
        int nfs;
        int nerr;
        sel       = 1'b1;
        pkt_ready = 1'b1;
        cnt       = 12'd12;
        tick();
        cnt  = 12'd0;
        nfs  = 0;
        nerr = 0;
        for (int i = 0; i < 25; i++) begin
            if (fs === 1'b1) nfs++;
            if (err === 1'b1) nerr++;
            tick();
        end
        n_chk++;
        if (nfs !== 16 || nerr !== 1) begin
            n_fail++;
            $display("FAIL tout_pulse: fs=%0d err=%0d cycles required 16 1", nfs, nerr);
        end
        n_chk++;
        if (tout !== 16'd1 || so !== 3'd0 || good !== 16'd0) begin
            n_fail++;
            $display("FAIL tout_cnt: tout=%0d so=%0d good=%0d required 1 0 0", tout, so, good);
        end
        cnt = 12'd12;
        tick();
        cnt = 12'd0;
        repeat (15) tick();
        rd_res = to_res(GOOD1);
        rd_fd  = 1'b1;
        tick();
        n_chk++;
        if (so !== 3'd2 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL tout_race: so=%0d err=%b required 2 0", so, err);
        end
        tick();
        n_chk++;
        if (pv !== 1'b1 || pd !== GOOD1) begin
            n_fail++;
            $display("FAIL tout_race_out: pv=%b data=%h required 1 %h", pv, pd, GOOD1);
        end
        finish_frame();
        n_chk++;
        if (good !== 16'd1 || tout !== 16'd1) begin
            n_fail++;
            $display("FAIL tout_race_cnt: good=%0d tout=%0d required 1 1", good, tout);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive_frame(BADH, 1);
            finish_frame();
        end
        n_chk++;
        if (bad !== 16'd15) begin
            n_fail++;
            $display("FAIL sat_fill: bad=%0d required 15", bad);
        end
        drive_frame(BADC, 0);
        finish_frame();
        n_chk++;
        if (bad !== 16'd15) begin
            n_fail++;
            $display("FAIL sat_hold: bad=%0d required 15", bad);
        end
    endtask

    task automatic test_reset_mid();
        sel       = 1'b1;
        pkt_ready = 1'b0;
        drive_frame(GOOD2, 2);
        n_chk++;
        if (pv !== 1'b1 || so !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_out: pv=%b so=%0d required 1 3", pv, so);
        end
        rst = 1'b1;
        tick();
        n_chk++;
        if ({so, fs, err, pv, busy} !== 7'd0 || pd !== 96'd0) begin
            n_fail++;
            $display("FAIL mid_reset: so=%0d fs=%b err=%b pv=%b busy=%b data=%h required 0",
                     so, fs, err, pv, busy, pd);
        end
        n_chk++;
        if ({good, bad, tout} !== 48'd0) begin
            n_fail++;
            $display("FAIL mid_reset_cnt: good=%0d bad=%0d tout=%0d required 0", good, bad, tout);
        end
        rst   = 1'b0;
        rd_fd = 1'b0;
        tick();
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        sel       = 1'b0;
        rst       = 1'b1;
        cnt       = 12'd0;
        frame_len = 12'd12;
        rd_fd     = 1'b0;
        rd_res    = '0;
        pkt_ready = 1'b0;
        test_reset();
        test_good();
        test_bad();
        test_back_pressure();
        test_boundary();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
